// File: rtl/vga_interface.sv
// vga_interface: VGA sync/timing generator with a 4-CLK pixel period and registered colour/sync outputs.
module vga_interface #(
    parameter int HVIS   = 640,
    parameter int HFP    = 16,
    parameter int HSW    = 96,
    parameter int HTOTAL = 800,
    parameter int VVIS   = 480,
    parameter int VFP    = 10,
    parameter int VSW    = 2,
    parameter int VTOTAL = 525
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] COLOUR_IN,
    output logic [9:0] ADDRH,
    output logic [8:0] ADDRV,
    output logic [7:0] COLOUR_OUT,
    output logic       HS,
    output logic       VS,
    output logic       FRAME_TICK
);
    localparam logic [9:0] H_VIS  = 10'(HVIS);
    localparam logic [9:0] H_LAST = 10'(HTOTAL - 1);
    localparam logic [9:0] HS_BEG = 10'(HVIS + HFP);
    localparam logic [9:0] HS_END = 10'(HVIS + HFP + HSW);
    localparam logic [9:0] V_VIS  = 10'(VVIS);
    localparam logic [9:0] V_LAST = 10'(VTOTAL - 1);
    localparam logic [9:0] VS_BEG = 10'(VVIS + VFP);
    localparam logic [9:0] VS_END = 10'(VVIS + VFP + VSW);

    logic [1:0] div_q, div_d;
    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [7:0] colour_q, colour_d;
    logic       hs_q, hs_d, vs_q, vs_d, tick_q, tick_d;
    logic       pix_en, h_end, v_end, h_vis, v_vis;

    always_comb begin
        pix_en   = div_q == 2'd3;
        h_end    = hcnt_q == H_LAST;
        v_end    = vcnt_q == V_LAST;
        h_vis    = hcnt_q < H_VIS;
        v_vis    = vcnt_q < V_VIS;
        div_d    = div_q + 2'd1;
        hcnt_d   = pix_en ? (h_end ? 10'd0 : hcnt_q + 10'd1) : hcnt_q;
        vcnt_d   = (pix_en && h_end) ? (v_end ? 10'd0 : vcnt_q + 10'd1) : vcnt_q;
        // Registered on pix_en so colour and both syncs share one pixel of latency.
        colour_d = pix_en ? ((h_vis && v_vis) ? COLOUR_IN : 8'h00) : colour_q;
        hs_d     = pix_en ? !(hcnt_q >= HS_BEG && hcnt_q < HS_END) : hs_q;
        vs_d     = pix_en ? !(vcnt_q >= VS_BEG && vcnt_q < VS_END) : vs_q;
        tick_d   = pix_en && h_end && v_end;
        ADDRH    = h_vis ? hcnt_q : 10'd0;
        ADDRV    = v_vis ? vcnt_q[8:0] : 9'd0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_q    <= 2'd0;
            hcnt_q   <= 10'd0;
            vcnt_q   <= 10'd0;
            colour_q <= 8'h00;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            colour_q <= colour_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            tick_q   <= tick_d;
        end
    end

    assign COLOUR_OUT = colour_q;
    assign HS         = hs_q;
    assign VS         = vs_q;
    assign FRAME_TICK = tick_q;
endmodule

// File: tb/tb_vga_interface.sv
// tb_vga_interface: directed checks of VGA timing with a short line and full-height frame.
module tb_vga_interface;
    localparam int HVIS = 8, HFP = 2, HSW = 3, HT = 16;
    localparam int VVIS = 480, VFP = 10, VSW = 2, VT = 525;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] colour_in = 8'h00;
    logic [9:0] addrh;
    logic [8:0] addrv;
    logic [7:0] colour_out;
    logic       hs, vs, frame_tick;
    bit         ff_mode = 1'b1;
    int         n_checks = 0, n_fail = 0, k = 0, hs_low = 0, vs_low = 0, ft_cnt = 0;

    vga_interface #(
        .HVIS(HVIS), .HFP(HFP), .HSW(HSW), .HTOTAL(HT),
        .VVIS(VVIS), .VFP(VFP), .VSW(VSW), .VTOTAL(VT)
    ) dut (
        .CLK(clk), .RESET(rst), .COLOUR_IN(colour_in),
        .ADDRH(addrh), .ADDRV(addrv), .COLOUR_OUT(colour_out),
        .HS(hs), .VS(vs), .FRAME_TICK(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] snake(input logic [9:0] a);
        return {a[3:0], ~a[3:0]};
    endfunction

    // Snake drawing stage: one registered CLK from ADDRH to COLOUR_IN.
    always_ff @(posedge clk) colour_in <= ff_mode ? 8'hFF : snake(addrh);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic check_cycle();
        int p, h, v, q, hq, vq;
        logic [7:0] e_col;
        logic e_hs, e_vs, e_ft;
        p = k / 4;
        h = p % HT;
        v = (p / HT) % VT;
        e_col = 8'h00; e_hs = 1'b1; e_vs = 1'b1; e_ft = 1'b0;
        if (k >= 4) begin
            q = p - 1;
            hq = q % HT;
            vq = (q / HT) % VT;
            if (hq < HVIS && vq < VVIS) e_col = ff_mode ? 8'hFF : snake(10'(hq));
            e_hs = !(hq >= HVIS + HFP && hq < HVIS + HFP + HSW);
            e_vs = !(vq >= VVIS + VFP && vq < VVIS + VFP + VSW);
            e_ft = (k % 4 == 0) && (p % (HT * VT) == 0);
        end
        check("addrh", addrh, (h < HVIS) ? h : 0);
        check("addrv", addrv, (v < VVIS) ? v : 0);
        check("colour_out", colour_out, e_col);
        check("hs", hs, e_hs);
        check("vs", vs, e_vs);
        check("frame_tick", frame_tick, e_ft);
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
        check_cycle();
        hs_low += int'(!hs);
        vs_low += int'(!vs);
        ft_cnt += int'(frame_tick);
        if (k == 4 * (HVIS + HFP) + 3) check("hs_before_pulse", hs, 1);
        if (k == 4 * (HVIS + HFP + 1)) check("hs_pulse_start", hs, 0);
        if (k == 4 * (479 * HT + HVIS - 1) + 2) begin
            check("addrh_last_col", addrh, HVIS - 1);
            check("addrv_last_row", addrv, 479);
        end
        if (k == 4 * (479 * HT + HVIS) + 2) check("addrh_first_porch", addrh, 0);
        if (k == 4 * (500 * HT + 3) + 2) check("addrv_no_alias", addrv, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_hs", hs, 1);
        check("rst_vs", vs, 1);
        check("rst_colour", colour_out, 0);
        check("rst_addrh", addrh, 0);
        check("rst_addrv", addrv, 0);
        check("rst_tick", frame_tick, 0);
        rst = 1'b0;
        k = 0;
    endtask

    initial begin
        @(negedge clk);
        ff_mode = 1'b1;
        do_reset();
        hs_low = 0; vs_low = 0; ft_cnt = 0;
        repeat (4 * HT * VT + 3) step();
        check("hs_low_clks_frame", hs_low, 4 * HSW * VT);
        check("vs_low_clks_frame", vs_low, 4 * HT * VSW);
        check("frame_ticks", ft_cnt, 1);
        repeat (4 * HT * 2) step();
        ff_mode = 1'b0;
        do_reset();
        repeat (4 * (2 * HT + 11) + 1) step();
        check("hs_low_before_rst", hs, 0);
        do_reset();
        repeat (4 * HT * 3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_interface.md
VGA_INTERFACE -- requirements
Module: vga_interface

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  - HVIS, 640, visible pixels per line
  - HFP, 16, horizontal front porch
  - HSW, 96, HS pulse width
  - HTOTAL, 800, pixels per line
  - VVIS, 480, visible lines
  - VFP, 10, vertical front porch
  - VSW, 2, VS pulse width
  - VTOTAL, 525, lines per frame
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - CLK, in, 1, system clock (100 MHz)
  - RESET, in, 1, synchronous active-high reset
  - COLOUR_IN, in, 8, pixel colour from the snake drawing stage; valid 1 CLK after the address changes
  - ADDRH, out, 10, current visible column
  - ADDRV, out, 9, current visible row
  - COLOUR_OUT, out, 8, registered colour to the DAC
  - HS, out, 1, horizontal sync, active low
  - VS, out, 1, vertical sync, active low
  - FRAME_TICK, out, 1, one-CLK pulse at end of frame
REQ-003 Design SHALL use one clock (CLK) and one reset (RESET), synchronous and active-high; no other clock or asynchronous logic.

Function
REQ-004 A 2-bit divider SHALL increment every CLK; pixel enable (pix_en) SHALL be high in the CLK where divider==3, giving one pixel per 4 CLKs.
REQ-005 Horizontal counter hcnt (10 bits) SHALL advance only on pix_en: 0..HTOTAL-1, then wrap to 0.
REQ-006 Vertical counter vcnt (10 bits) SHALL advance on pix_en when hcnt==HTOTAL-1: 0..VTOTAL-1, then wrap to 0.
REQ-007 Horizontal regions SHALL be:
  - visible: hcnt 0..HVIS-1
  - front porch: HVIS..HVIS+HFP-1 (640..655)
  - sync: HVIS+HFP..HVIS+HFP+HSW-1 (656..751)
  - back porch: 752..HTOTAL-1
REQ-008 Vertical regions SHALL be:
  - visible: 0..479
  - front porch: 480..489
  - sync: 490..491
  - back porch: 492..524
REQ-009 ADDRH SHALL equal hcnt while hcnt<HVIS, else 0; ADDRV SHALL equal vcnt[8:0] while vcnt<VVIS, else 0; both combinational from the counters.
REQ-010 On pix_en, COLOUR_OUT SHALL load COLOUR_IN if (hcnt<HVIS and vcnt<VVIS), else 8'h00; it SHALL hold between pix_en cycles.
REQ-011 On pix_en, HS SHALL load 0 iff hcnt is in the sync region, else 1; VS SHALL load 0 iff vcnt is in the sync region, else 1. This gives HS, VS and COLOUR_OUT identical one-pixel latency relative to the counters.
REQ-012 FRAME_TICK SHALL be 1 for exactly one CLK, the CLK after the pix_en where hcnt==HTOTAL-1 and vcnt==VTOTAL-1; it SHALL be 0 otherwise.
REQ-013 Counter comparisons SHALL use full 10-bit width; ADDRV truncation to 9 bits SHALL occur only after the visible check, so no alias appears for vcnt>=512.
REQ-014 The pixel period SHALL be 4 CLKs, so COLOUR_IN has 3 settled CLKs before its sampling pix_en; the block SHALL add no other colour pipeline stage.

Reset
REQ-015 While RESET is high at a CLK edge, the following SHALL load these values, overriding pix_en:
  - divider, hcnt, vcnt: 0
  - COLOUR_OUT: 8'h00
  - HS, VS: 1
  - FRAME_TICK: 0
REQ-016 RESET asserted mid-line or mid-frame SHALL restart timing at hcnt=0, vcnt=0, with no partial sync pulse continuing after reset.
REQ-017 After RESET deasserts, the first pix_en SHALL occur on the 4th CLK edge.

Verification
REQ-018 The bench SHALL cover these scenarios:
  - Reset, then run 4*800 CLKs: pix_en every 4th CLK; hcnt 0..799 then 0; HS low exactly 96 pixels (384 CLKs), starting after the pix_en at hcnt=656.
  - Run a full frame (4*800*525 = 1,680,000 CLKs): VS low exactly 2 lines (6400 CLKs) starting at vcnt=490; exactly one FRAME_TICK per frame, one CLK wide.
  - Drive COLOUR_IN=8'hFF constantly: COLOUR_OUT=8'hFF only for pixels hcnt<640 and vcnt<480, and 8'h00 in all porch/sync pixels.
  - Check ADDRH/ADDRV at hcnt=639, vcnt=479: 639 and 479; at hcnt=640: ADDRH=0; at vcnt=500: ADDRV=0 (not 500 mod 512).
  - Assert RESET for 1 CLK at hcnt=700 (inside HS pulse): next CLK has HS=1, hcnt=0, COLOUR_OUT=0; the next HS pulse begins at hcnt=656 of the new line.
  - Model the snake drawing stage as a 1-CLK registered function of ADDRH: COLOUR_OUT at pixel n SHALL equal f(n) with no off-by-one column shift.
